// File: rtl/bcd_to_bin.sv
// bcd_to_bin: converts a three-digit packed BCD value (0..999) to a 10-bit binary
// number using reverse double-dabble, one bit per clock. A request with any
// digit above 9 returns at once with err set and a result of 0.
module bcd_to_bin #(
  parameter int unsigned ENA = 1   // 0: every accepted request returns 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  output logic [9:0] bin,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [11:0] bcd_q;    // remaining BCD value, drained one bit per step
  logic [9:0]  sh_q;     // binary result, filled from the top
  logic [3:0]  cnt_q;    // steps remaining

  logic [21:0] shifted;
  logic [11:0] bcd_nxt;
  logic        bad_digit;

  // One reverse double-dabble step: shift right, then undo the decimal
  // carry in every nibble that now reads 8 or more (msb set).
  always_comb begin
    shifted = {bcd_q, sh_q} >> 1;
    bcd_nxt = shifted[21:10];
    for (int i = 0; i < 3; i++) begin
      if (shifted[10 + 4*i + 3])
        bcd_nxt[4*i +: 4] = shifted[10 + 4*i +: 4] - 4'd3;
    end
    bad_digit = (digit2 > 4'd9) || (digit1 > 4'd9) || (digit0 > 4'd9);
  end

  // Control FSM and datapath registers; outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bcd_q <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
      bin   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bcd_q <= {digit2, digit1, digit0};
            sh_q  <= '0;
            cnt_q <= 4'd10;
            if (bad_digit) begin
              state <= DONE;
              bin   <= '0;
              err   <= 1'b1;
              done  <= 1'b1;
            end else if (ENA == 0) begin
              state <= DONE;
              bin   <= '0;
              err   <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          bcd_q <= bcd_nxt;
          sh_q  <= shifted[9:0];
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state <= DONE;
            bin   <= shifted[9:0];
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: directed vector table plus hand-written sequences for
// held start, mid-conversion reset and the disabled (ENA=0) build.
module tb_bcd_to_bin;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start0 = 1'b0;
  logic [3:0] digit2 = '0, digit1 = '0, digit0 = '0;
  logic [9:0] bin, bin0;
  logic       busy, done, err, busy0, done0, err0;

  int total = 0;
  int bad = 0;
  int last_bin = 0;

  always #5 clk = ~clk;

  bcd_to_bin #(.ENA(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .bin(bin), .busy(busy), .done(done), .err(err)
  );

  bcd_to_bin #(.ENA(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .bin(bin0), .busy(busy0), .done(done0), .err(err0)
  );

  typedef struct {
    logic [3:0] d2, d1, d0;
    int         b;
    int         e;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Issue a one-cycle request and follow it to its done pulse.
  task automatic conv(input logic [3:0] d2, d1, d0, input int exp_b, input int exp_e);
    int cyc = 0;
    int busy_bad = 0;
    int hold_bad = 0;
    int exp_lat = exp_e ? 0 : 10;
    digit2 = d2; digit1 = d1; digit0 = d0; start = 1'b1;
    @(negedge clk);              // edge k has passed
    start = 1'b0;
    digit2 = 4'hF; digit1 = 4'hF; digit0 = 4'hF;   // must not matter now
    while (!done && cyc < 40) begin
      if (busy !== 1'(!exp_e)) busy_bad++;
      if (int'(bin) != last_bin) hold_bad++;
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("latency %0x%0x%0x", d2, d1, d0), cyc, exp_lat);
    chk($sformatf("bin %0x%0x%0x", d2, d1, d0), int'(bin), exp_b);
    chk($sformatf("err %0x%0x%0x", d2, d1, d0), int'(err), exp_e);
    chk("busy during conversion", busy_bad, 0);
    chk("bin held during conversion", hold_bad, 0);
    chk("busy low at done", int'(busy), 0);
    if (!exp_e) chk("bcd register drained", int'(dut.bcd_q), 0);
    @(negedge clk);
    chk("done single pulse", int'(done), 0);
    last_bin = exp_b;
  endtask

  initial begin
    tbl[0] = '{4'd9, 4'd9, 4'd9, 999, 0};
    tbl[1] = '{4'd2, 4'd5, 4'd5, 255, 0};
    tbl[2] = '{4'd0, 4'd0, 4'd0, 0,   0};
    tbl[3] = '{4'd1, 4'hA, 4'd3, 0,   1};
    tbl[4] = '{4'd0, 4'd4, 4'd2, 42,  0};
    tbl[5] = '{4'd5, 4'd1, 4'd2, 512, 0};
    tbl[6] = '{4'hF, 4'd0, 4'd0, 0,   1};
    tbl[7] = '{4'd0, 4'd0, 4'd9, 9,   0};
    tbl[8] = '{4'd1, 4'd0, 4'd0, 100, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset bin", int'(bin), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset err", int'(err), 0);

    // Release and request on the very next edge
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++)
      conv(tbl[i].d2, tbl[i].d1, tbl[i].d0, tbl[i].b, tbl[i].e);

    // start held high: one conversion per 12 cycles, digits changed at k+3
    begin
      int cyc = 0;
      int first_at = -1;
      digit2 = 4'd1; digit1 = 4'd2; digit0 = 4'd3; start = 1'b1;
      @(negedge clk);            // edge k
      while (cyc < 40) begin
        if (cyc == 3) begin digit2 = 4'd4; digit1 = 4'd5; digit0 = 4'd6; end
        if (done) begin
          if (first_at < 0) begin
            first_at = cyc;
            chk("held start first bin", int'(bin), 123);
            chk("held start first latency", cyc, 10);
          end else begin
            chk("held start second bin", int'(bin), 456);
            chk("held start interval", cyc - first_at, 12);
            break;
          end
        end
        @(negedge clk);
        cyc++;
      end
      chk("held start second seen", int'(cyc < 40), 1);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      last_bin = 456;
    end

    // Reset in the middle of a 9,8,7 conversion
    begin
      int seen = 0;
      digit2 = 4'd9; digit1 = 4'd8; digit0 = 4'd7; start = 1'b1;
      @(negedge clk);            // edge k
      start = 1'b0;
      repeat (5) @(negedge clk); // edges k+1..k+5 done
      rst_n = 1'b0;
      #1;
      chk("abort bin", int'(bin), 0);
      chk("abort busy", int'(busy), 0);
      chk("abort done", int'(done), 0);
      chk("abort err", int'(err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("no done after abort", seen, 0);
      last_bin = 0;
      conv(4'd9, 4'd8, 4'd7, 987, 0);
    end

    // Disabled build returns 0 immediately
    digit2 = 4'd5; digit1 = 4'd5; digit0 = 4'd5; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("ENA0 done", int'(done0), 1);
    chk("ENA0 bin", int'(bin0), 0);
    chk("ENA0 err", int'(err0), 0);
    chk("ENA0 busy", int'(busy0), 0);
    @(negedge clk);
    chk("ENA0 done pulse", int'(done0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
